dgram_rx_buffer: RTL and testbench
==================================

# dgram_rx_buffer

Parametrised childboard receive front-end. Accepts a datagram from the motherboard as a sequence of CHUNK_W-bit chunks over a four-phase req/ack link, and reassembles it into MSG_W bits. Holds the completed message in a pending register and commits it to the renderer on a frame boundary, so the display never shows a half-updated datagram. It sits between the board-to-board pins and the output interface. It replaces the fixed-width receiver and latch pair.

## Interface
Parameters:
- MSG_W, default 48: datagram width in bits.
- CHUNK_W, default 6: bits per transferred chunk.
- SYNC_STAGES, default 2: flops on the req synchroniser; must be 2 or more.
- TIMEOUT_CYC, default 1024: idle cycles tolerated mid-message before it is aborted.

Derived: N = ceil(MSG_W/CHUNK_W) chunks per message.

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: synchronous, active-low reset.
- req_in, input, 1: asynchronous request from the motherboard.
- data_in, input, CHUNK_W: chunk payload, bundled with req_in.
- sof_in, input, 1: start-of-frame flag, bundled with req_in; 1 on chunk 0 only.
- frame_tick, input, 1: one-cycle commit strobe from VGA timing (vblank start).
- ack_out, output, 1: acknowledge to the motherboard, registered.
- datagram_out, output, MSG_W: committed datagram.
- datagram_valid, output, 1: high once the first datagram is committed; sticky.
- datagram_upd, output, 1: one-cycle pulse on every commit.
- rx_error, output, 1: one-cycle pulse on a framing error or timeout.
- overrun, output, 1: one-cycle pulse when an uncommitted pending message is overwritten.

## Operation
- req_in passes through SYNC_STAGES flops to give req_s. data_in and sof_in are sampled raw; they are guaranteed stable while req_in is high.
- States: IDLE, ACK, GAP.
- IDLE:
  - On req_s=1 with sof_in=1: write the chunk to slot 0, set idx to 1, set ack_out to 1, go to ACK.
  - On req_s=1 with sof_in=0: set ack_out to 1, discard the chunk, pulse rx_error, go to ACK with a drop flag set. The handshake still completes so the sender never stalls.
- ACK: on req_s=0, set ack_out to 0.
  - If drop is set, or idx==N: go to IDLE. When idx==N the message is complete.
  - Otherwise go to GAP.
- GAP:
  - On req_s=1 with sof_in=0: write the chunk to slot idx, increment idx, set ack_out to 1, go to ACK.
  - On req_s=1 with sof_in=1: pulse rx_error, restart the message (slot 0, idx set to 1), go to ACK.
- Slot k occupies bits [k*CHUNK_W +: CHUNK_W]; the message is sent LSB chunk first. Bits of the last chunk above MSG_W-1 are dropped.
- Timeout:
  - The counter clears on each req_s edge and counts while the state is ACK or GAP.
  - When it reaches TIMEOUT_CYC: go to IDLE, set idx to 0, set ack_out to 0, clear drop, pulse rx_error. The partial message is discarded.
- On message completion (ACK to IDLE with idx==N): set pending to the assembled message and pending_full to 1. If pending_full was already 1, pulse overrun; the latest message wins.
- Commit: on frame_tick with pending_full=1, set datagram_out to pending, clear pending_full, set datagram_valid to 1, pulse datagram_upd. frame_tick with pending_full=0 does nothing.
- Completion and frame_tick in the same cycle: the commit takes the old pending content if pending_full was 1. The new message then lands in pending with no overrun. If pending was empty, the new message waits for the next tick.
- rst low at any edge:
  - State becomes IDLE; ack_out, idx, timeout, pending_full and drop become 0; datagram_out becomes 0; all pulse outputs become 0; the synchroniser flops become 0.
  - A transfer in progress is abandoned. The sender recovers through its own timeout and resends from sof.

## Timing
- Reset values: ack_out=0, datagram_out=0, datagram_valid=0, datagram_upd=0, rx_error=0, overrun=0.
- req_in rise to ack_out rise: SYNC_STAGES+1 clk edges. req_in fall to ack_out fall: SYNC_STAGES+1 edges.
- Last-chunk req_s fall: pending is valid on the edge that drops ack_out.
- Commit latency: datagram_out and datagram_upd are updated on the edge that samples frame_tick=1.
- The idx width is max(1, clog2(N+1)). The timeout counter width is clog2(TIMEOUT_CYC+1); it saturates and never wraps.

## Configuration
- RX_FRAME_SYNC_EN defined: frame-synchronous commit through the pending register, exactly as described above.
- RX_FRAME_SYNC_EN undefined:
  - The pending register is omitted.
  - Completion writes datagram_out directly on the completion edge, pulses datagram_upd and sets datagram_valid.
  - frame_tick is ignored and overrun is tied to 0.

## Test plan
- Reset, then a complete 8-chunk message 0x0123456789AB (defaults) with a frame_tick 50 cycles later -> each ack_out rises SYNC_STAGES+1=3 edges after req_in; datagram_out=0x0123456789AB and datagram_upd pulses on the tick edge; datagram_valid=1.
- Chunk without sof in IDLE -> handshake completes, rx_error pulses once, pending is unchanged, no datagram_upd.
- 3 chunks sent, then req_in held low 1024 cycles -> rx_error at cycle 1024, ack_out=0; the next full message commits correctly.
- Two complete messages A then B before one frame_tick -> overrun pulses once; the tick commits B.
- Completion and frame_tick in the same cycle, with pending holding A -> A commits; B commits on the next tick; overrun stays 0.
- rst low for 1 cycle after chunk 4 -> ack_out=0 and datagram_out=0; a resent full message from sof commits normally. With RX_FRAME_SYNC_EN undefined, datagram_out updates on the completion edge with no tick.

Source files
------------

// File: rtl/dgram_rx_buffer.sv
`timescale 1ns/1ps
// dgram_rx_buffer
// Receive front-end for a childboard. It collects a datagram from the
// motherboard as CHUNK_W-bit chunks over a four-phase req/ack link and
// reassembles them into an MSG_W-bit message.
//
// Optional feature macro: RX_FRAME_SYNC_EN
//   defined   : a completed message is parked in a pending register and is
//               committed to datagram_out on the next frame_tick, so the
//               renderer never sees a half-updated datagram.
//   undefined : a completed message is written to datagram_out on the
//               completion edge. frame_tick is ignored and overrun stays 0.
//
// Handshake (four-phase, sender-driven):
//   The sender presents data_in/sof_in and raises req_in. Both stay stable
//   while req_in is high. The receiver samples the chunk and raises ack_out.
//   The sender then drops req_in, and the receiver answers by dropping
//   ack_out. Only then may the next chunk start. Every chunk is
//   acknowledged, including rejected ones, so the sender never stalls.
//   req_in is asynchronous and passes through SYNC_STAGES flops (>= 2).
//
// o_dbg_state exposes the receive FSM state (0=IDLE, 1=ACK, 2=GAP).
module dgram_rx_buffer #(
    parameter int MSG_W       = 48,
    parameter int CHUNK_W     = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_in,
    input  logic [CHUNK_W-1:0] data_in,
    input  logic               sof_in,
    input  logic               frame_tick,
    output logic               ack_out,
    output logic [MSG_W-1:0]   datagram_out,
    output logic               datagram_valid,
    output logic               datagram_upd,
    output logic               rx_error,
    output logic               overrun,
    output logic [1:0]         o_dbg_state
);

    // Chunks per message. The last chunk may carry bits above MSG_W-1; those
    // bits land in the assembly buffer but never reach the output.
    localparam int N     = (MSG_W + CHUNK_W - 1) / CHUNK_W;
    localparam int ASM_W = N * CHUNK_W;
    localparam int IDX_W = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req_d;
    state_t                 r_state;
    logic                   r_ack;
    logic                   r_drop;
    logic [IDX_W-1:0]       r_idx;
    logic [ASM_W-1:0]       r_asm;
    logic                   r_rx_error;
    logic [TO_W-1:0]        r_to_cnt;
    logic [MSG_W-1:0]       r_dout;
    logic                   r_valid;
    logic                   r_upd;

    logic                   w_req_s;
    logic                   w_req_edge;
    logic                   w_counting;
    logic [TO_W-1:0]        w_to_next;
    logic                   w_timeout;
    logic                   w_complete;
    logic [MSG_W-1:0]       w_msg;

    // ------------------------------------------------------------------
    // req synchroniser and edge detect
    // ------------------------------------------------------------------
    assign w_req_s    = r_sync[SYNC_STAGES-1];
    assign w_req_edge = w_req_s ^ r_req_d;

    // Shift the asynchronous request through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync  <= '0;
            r_req_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], req_in};
            r_req_d <= w_req_s;
        end
    end

    // ------------------------------------------------------------------
    // Mid-message idle timeout
    // ------------------------------------------------------------------
    // The counter measures how long the link has been quiet while a message
    // is open. The abort fires on the edge at which the count would reach
    // TIMEOUT_CYC, so the error pulse appears TIMEOUT_CYC edges after the
    // last req_s transition.
    assign w_counting = (r_state != S_IDLE);
    assign w_to_next  = (r_to_cnt == TO_MAX) ? TO_MAX : r_to_cnt + 1'b1;
    assign w_timeout  = w_counting && !w_req_edge && (w_to_next == TO_MAX);

    // Count quiet cycles while the message is open, saturating at TIMEOUT_CYC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (!w_counting || w_req_edge || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_next;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: handshake, slot writes, framing errors
    // ------------------------------------------------------------------
    // A message completes when the last chunk's req falls: the FSM is in ACK,
    // sees req_s low, the chunk was not dropped and all N slots are written.
    assign w_complete = (r_state == S_ACK) && !w_req_s && !r_drop &&
                        (r_idx == IDX_LAST) && !w_timeout;
    assign w_msg      = r_asm[MSG_W-1:0];

    // Drive ack_out, assemble chunks into slots and flag framing errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ack      <= 1'b0;
            r_drop     <= 1'b0;
            r_idx      <= '0;
            r_asm      <= '0;
            r_rx_error <= 1'b0;
        end else begin
            r_rx_error <= 1'b0;
            if (w_timeout) begin
                // The sender went quiet mid-message. Drop the partial message.
                r_state    <= S_IDLE;
                r_ack      <= 1'b0;
                r_drop     <= 1'b0;
                r_idx      <= '0;
                r_rx_error <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_req_s) begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                            if (sof_in) begin
                                r_asm[CHUNK_W-1:0] <= data_in;
                                r_idx              <= IDX_W'(1);
                                r_drop             <= 1'b0;
                            end else begin
                                // Orphan chunk: acknowledge it but throw it away.
                                r_drop     <= 1'b1;
                                r_rx_error <= 1'b1;
                            end
                        end
                    end
                    S_ACK: begin
                        if (!w_req_s) begin
                            r_ack <= 1'b0;
                            if (r_drop || (r_idx == IDX_LAST)) begin
                                r_state <= S_IDLE;
                                r_idx   <= '0;
                                r_drop  <= 1'b0;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_req_s) begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                            if (sof_in) begin
                                // A new message began early: restart from slot 0.
                                r_asm[CHUNK_W-1:0] <= data_in;
                                r_idx              <= IDX_W'(1);
                                r_rx_error         <= 1'b1;
                            end else begin
                                for (int k = 0; k < N; k++) begin
                                    if (r_idx == IDX_W'(k)) begin
                                        r_asm[k*CHUNK_W +: CHUNK_W] <= data_in;
                                    end
                                end
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_drop  <= 1'b0;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit path
    // ------------------------------------------------------------------
`ifdef RX_FRAME_SYNC_EN
    logic [MSG_W-1:0] r_pending;
    logic             r_pending_full;
    logic             r_overrun;
    logic             w_commit;

    assign w_commit = frame_tick && r_pending_full;

    // Park each completed message until the next frame boundary. A message
    // completing on the tick edge refills pending after the old one commits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending      <= '0;
            r_pending_full <= 1'b0;
        end else if (w_complete) begin
            r_pending      <= w_msg;
            r_pending_full <= 1'b1;
        end else if (w_commit) begin
            r_pending_full <= 1'b0;
        end
    end

    // Commit pending on frame_tick and report an overwritten pending message.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_upd     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_upd     <= 1'b0;
            r_overrun <= 1'b0;
            if (w_commit) begin
                r_dout  <= r_pending;
                r_valid <= 1'b1;
                r_upd   <= 1'b1;
            end
            if (w_complete && r_pending_full && !w_commit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_tick;
    assign w_unused_tick = frame_tick;

    // Write each completed message straight to the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_complete) begin
                r_dout  <= w_msg;
                r_valid <= 1'b1;
                r_upd   <= 1'b1;
            end
        end
    end

    assign overrun = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack_out        = r_ack;
    assign datagram_out   = r_dout;
    assign datagram_valid = r_valid;
    assign datagram_upd   = r_upd;
    assign rx_error       = r_rx_error;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dgram_rx_buffer.sv
`timescale 1ns/1ps
// Bench for dgram_rx_buffer. It keeps a message-level model (committed value,
// pending slot, expected pulse counts and an expected commit queue). The
// model works in either commit mode, selected by RX_FRAME_SYNC_EN.
module tb_dgram_rx_buffer;

    localparam int MSG_W       = 48;
    localparam int CHUNK_W     = 6;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 1024;
    localparam int N           = 8;
    localparam int HS_LAT      = SYNC_STAGES + 1;

`ifdef RX_FRAME_SYNC_EN
    localparam bit SYNC_MODE = 1'b1;
`else
    localparam bit SYNC_MODE = 1'b0;
`endif

    // ------------------------------------------------------------------
    // DUT signals and instance
    // ------------------------------------------------------------------
    logic               clk;
    logic               rst;
    logic               req_in;
    logic [CHUNK_W-1:0] data_in;
    logic               sof_in;
    logic               frame_tick;
    logic               ack_out;
    logic [MSG_W-1:0]   datagram_out;
    logic               datagram_valid;
    logic               datagram_upd;
    logic               rx_error;
    logic               overrun;
    logic [1:0]         dbg_state;

    dgram_rx_buffer #(
        .MSG_W       (MSG_W),
        .CHUNK_W     (CHUNK_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_in         (req_in),
        .data_in        (data_in),
        .sof_in         (sof_in),
        .frame_tick     (frame_tick),
        .ack_out        (ack_out),
        .datagram_out   (datagram_out),
        .datagram_valid (datagram_valid),
        .datagram_upd   (datagram_upd),
        .rx_error       (rx_error),
        .overrun        (overrun),
        .o_dbg_state    (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping and model state
    // ------------------------------------------------------------------
    int n_tests  = 0;
    int n_fail   = 0;
    int n_prints = 0;

    logic [MSG_W-1:0] m_dout      = '0;
    logic             m_valid     = 1'b0;
    logic [MSG_W-1:0] m_pend      = '0;
    bit               m_pend_full = 1'b0;
    int               m_upd = 0, m_err = 0, m_ovr = 0;
    int               s_upd = 0, s_err = 0, s_ovr = 0;
    bit               cmp_en = 1'b0;
    logic [MSG_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_commit(input logic [MSG_W-1:0] v);
        m_dout  = v;
        m_valid = 1'b1;
        m_upd++;
        exp_q.push_back(v);
    endtask

    // A whole message has arrived; tick says frame_tick hit the same edge.
    task automatic model_complete(input logic [MSG_W-1:0] msg, input bit tick, output bit committed);
        committed = 1'b0;
        if (SYNC_MODE) begin
            if (tick && m_pend_full) begin
                model_commit(m_pend);
                committed = 1'b1;
            end else if (m_pend_full) begin
                m_ovr++;
            end
            m_pend      = msg;
            m_pend_full = 1'b1;
        end else begin
            model_commit(msg);
            committed = 1'b1;
        end
    endtask

    task automatic model_tick(output bit committed);
        committed = 1'b0;
        if (SYNC_MODE && m_pend_full) begin
            model_commit(m_pend);
            m_pend_full = 1'b0;
            committed   = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_dout      = '0;
        m_valid     = 1'b0;
        m_pend      = '0;
        m_pend_full = 1'b0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare and pulse monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if (datagram_out !== m_dout || datagram_valid !== m_valid) begin
                n_fail++;
                if (n_prints < 20) begin
                    n_prints++;
                    $display("FAIL cycle_cmp: dout=%h valid=%b expected dout=%h valid=%b (t=%0t)",
                             datagram_out, datagram_valid, m_dout, m_valid, $time);
                end
            end
            if (datagram_upd === 1'b1) begin
                s_upd++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL upd_unexpected: datagram_upd=1 dout=%h with no commit expected (t=%0t)",
                             datagram_out, $time);
                end else begin
                    logic [MSG_W-1:0] e;
                    e = exp_q.pop_front();
                    if (datagram_out !== e) begin
                        n_fail++;
                        $display("FAIL commit_value: got %h expected %h (t=%0t)", datagram_out, e, $time);
                    end
                end
            end
            if (rx_error === 1'b1) s_err++;
            if (overrun === 1'b1)  s_ovr++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One four-phase chunk. With tick_on_fall set, frame_tick is raised so it
    // is sampled on the same edge that drops ack_out. tick_hit reports this.
    task automatic send_chunk(input logic [CHUNK_W-1:0] d, input bit sof,
                              input bit tick_on_fall, output bit tick_hit);
        int lat;
        @(posedge clk); #1;
        data_in = d;
        sof_in  = sof;
        req_in  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ack_out !== 1'b1 && lat < 20);
        check("ack_rise_latency", lat, HS_LAT);
        req_in   = 1'b0;
        lat      = 0;
        tick_hit = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (frame_tick) begin
                frame_tick = 1'b0;
                tick_hit   = 1'b1;
            end
            if (tick_on_fall && lat == HS_LAT - 1 && ack_out === 1'b1) frame_tick = 1'b1;
        end while (ack_out !== 1'b0 && lat < 20);
        frame_tick = 1'b0;
        check("ack_fall_latency", lat, HS_LAT);
    endtask

    task automatic send_partial(input logic [MSG_W-1:0] msg, input int count);
        bit hit;
        for (int k = 0; k < count; k++) begin
            send_chunk(msg[k*CHUNK_W +: CHUNK_W], (k == 0), 1'b0, hit);
        end
    endtask

    task automatic send_msg(input logic [MSG_W-1:0] msg, input bit tick_on_last);
        bit hit;
        bit committed;
        for (int k = 0; k < N; k++) begin
            send_chunk(msg[k*CHUNK_W +: CHUNK_W], (k == 0), tick_on_last && (k == N - 1), hit);
        end
        model_complete(msg, hit, committed);
        check("upd_at_completion", datagram_upd, committed);
    endtask

    task automatic send_tick();
        bit committed;
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        model_tick(committed);
        check("upd_at_tick", datagram_upd, committed);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst    = 1'b0;
        req_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_counts();
        @(negedge clk); #1;
        check("upd_count", s_upd, m_upd);
        check("rx_error_count", s_err, m_err);
        check("overrun_count", s_ovr, m_ovr);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        bit hit;
        int k;
        rst        = 1'b0;
        req_in     = 1'b0;
        data_in    = '0;
        sof_in     = 1'b0;
        frame_tick = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", ack_out, 1'b0);
        check("reset_dout", datagram_out, 48'h0);
        check("reset_valid", datagram_valid, 1'b0);
        check("reset_upd", datagram_upd, 1'b0);
        check("reset_rx_error", rx_error, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // Full message, then a tick 50 cycles later.
        send_msg(48'h0123456789AB, 1'b0);
        repeat (50) @(posedge clk);
        send_tick();
        check("msg1_dout_literal", datagram_out, 48'h0123456789AB);
        check("msg1_valid_literal", datagram_valid, 1'b1);
        check_counts();

        // Orphan chunk in IDLE: acknowledged, flagged, nothing committed.
        send_chunk(6'h15, 1'b0, 1'b0, hit);
        m_err++;
        send_tick();
        check("orphan_dout_literal", datagram_out, 48'h0123456789AB);
        check_counts();

        // Three chunks, then silence until the timeout aborts the message.
        send_partial(48'hFEDCBA987654, 3);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (rx_error !== 1'b1 && k < TIMEOUT_CYC + 100);
        m_err++;
        check("timeout_cycles", k, TIMEOUT_CYC);
        check("timeout_ack_low", ack_out, 1'b0);
        send_msg(48'h5A5A0F0FA5A5, 1'b0);
        send_tick();
        check("after_timeout_dout_literal", datagram_out, 48'h5A5A0F0FA5A5);
        check_counts();

        // sof arriving mid-message restarts it with an error pulse.
        send_partial(48'h111111111111, 2);
        m_err++;
        send_msg(48'h0000FFFF0001, 1'b0);
        send_tick();
        check("restart_dout_literal", datagram_out, 48'h0000FFFF0001);
        check_counts();

        // Two messages before one tick: the later one wins.
        send_msg(48'hCAFEBABE1234, 1'b0);
        send_msg(48'h13579BDF2468, 1'b0);
        send_tick();
        check("overrun_dout_literal", datagram_out, 48'h13579BDF2468);
        check_counts();

        // Completion on the tick edge while pending holds the previous message.
        send_msg(48'h0F1E2D3C4B5A, 1'b0);
        send_msg(48'h8796A5B4C3D2, 1'b1);
        check_counts();
        send_tick();
        check("same_edge_dout_literal", datagram_out, 48'h8796A5B4C3D2);
        check_counts();

        // Reset after chunk 4, then a full resend from sof.
        send_partial(48'h2468ACE13579, 4);
        pulse_reset();
        check("midreset_ack", ack_out, 1'b0);
        check("midreset_dout", datagram_out, 48'h0);
        check("midreset_valid", datagram_valid, 1'b0);
        send_msg(48'h2468ACE13579, 1'b0);
        send_tick();
        check("resend_dout_literal", datagram_out, 48'h2468ACE13579);
        check("resend_valid_literal", datagram_valid, 1'b1);

        repeat (10) @(posedge clk);
        check_counts();
        check("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit reached");
    end

endmodule
